// File: rtl/axi_rd_scheduler_pkg.sv
// Shared types and constants for the AXI read scheduler: request descriptor,
// requester indices and default bus widths.
package axi_rd_scheduler_pkg;

    localparam int unsigned RD_NUM_REQ         = 3;
    localparam int unsigned PHY_ADDR_W         = 40;
    localparam int unsigned MEM_ID_W           = 4;
    localparam int unsigned MEM_DATA_W         = 512;
    localparam int unsigned RD_MAX_OUTSTANDING = 4;

    localparam int unsigned REQ_ICACHE = 0;
    localparam int unsigned REQ_DMISS  = 1;
    localparam int unsigned REQ_DUC    = 2;

    typedef struct packed {
        logic [PHY_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [MEM_ID_W-1:0]   id;
    } rd_req_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_rd_scheduler_if.sv
// Requester, AR/R and response signals of the read scheduler. The master modport is the
// scheduler's view; slave is the view of everything around it.
interface axi_rd_scheduler_if #(
    parameter int unsigned NUM_REQ = axi_rd_scheduler_pkg::RD_NUM_REQ,
    parameter int unsigned ADDR_W  = axi_rd_scheduler_pkg::PHY_ADDR_W,
    parameter int unsigned ID_W    = axi_rd_scheduler_pkg::MEM_ID_W,
    parameter int unsigned DATA_W  = axi_rd_scheduler_pkg::MEM_DATA_W
) ();

    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*8-1:0]      req_len_i;
    logic [NUM_REQ*ID_W-1:0]   req_id_i;
    logic                      ar_valid_o;
    logic                      ar_ready_i;
    logic [ADDR_W-1:0]         ar_addr_o;
    logic [7:0]                ar_len_o;
    logic [ID_W-1:0]           ar_id_o;
    logic                      r_valid_i;
    logic                      r_ready_o;
    logic [ID_W-1:0]           r_id_i;
    logic                      r_last_i;
    logic [DATA_W-1:0]         r_data_i;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic [NUM_REQ-1:0]        rsp_ready_i;
    logic                      rsp_last_o;
    logic [DATA_W-1:0]         rsp_data_o;
    logic                      err_o;

    modport master (
        input  req_valid_i, req_addr_i, req_len_i, req_id_i, ar_ready_i,
        input  r_valid_i, r_id_i, r_last_i, r_data_i, rsp_ready_i,
        output req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_id_o,
        output r_ready_o, rsp_valid_o, rsp_last_o, rsp_data_o, err_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_len_i, req_id_i, ar_ready_i,
        output r_valid_i, r_id_i, r_last_i, r_data_i, rsp_ready_i,
        input  req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_id_o,
        input  r_ready_o, rsp_valid_o, rsp_last_o, rsp_data_o, err_o
    );

endinterface

// File: rtl/mem_rr_picker.sv
// Round-robin picker: first eligible requester at or after the pointer, wrapping.
module mem_rr_picker
    import axi_rd_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ = RD_NUM_REQ,
    localparam int unsigned IdxW   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               valid_o
);

    always_comb begin
        int unsigned cand;
        cand    = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr_i) + off) % NUM_REQ;
            if (!valid_o && eligible_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_rd_scheduler.sv
// Shares one AXI AR/R read path among several requesters: round-robin AR grant, one burst
// in flight per ID, per-requester outstanding cap, R beats routed to the owner of r_id_i.
module axi_rd_scheduler
    import axi_rd_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ         = RD_NUM_REQ,
    parameter int unsigned ADDR_W          = PHY_ADDR_W,
    parameter int unsigned ID_W            = MEM_ID_W,
    parameter int unsigned DATA_W          = MEM_DATA_W,
    parameter int unsigned MAX_OUTSTANDING = RD_MAX_OUTSTANDING
) (
    input logic               clk_i,
    input logic               rst_i,
    axi_rd_scheduler_if.master bus
);

    localparam int unsigned IdxW   = idx_w(NUM_REQ);
    localparam int unsigned CntW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned NumIds = 2 ** ID_W;

    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [NumIds-1:0] busy_q, busy_d;
    logic [IdxW-1:0]   owner_q [NumIds];
    logic [IdxW-1:0]   owner_d [NumIds];
    logic [CntW-1:0]   cnt_q [NUM_REQ];
    logic [CntW-1:0]   cnt_d [NUM_REQ];
    rd_req_t           ar_q, ar_d;
    logic              ar_valid_q, ar_valid_d;
    logic              err_q, err_d;

    rd_req_t           req [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_valid;
    logic               grant_valid;
    logic [IdxW-1:0]    r_owner;
    logic               r_busy;
    logic               r_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               r_done;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req[i].addr = bus.req_addr_i[i*ADDR_W +: ADDR_W];
            req[i].len  = bus.req_len_i[i*8 +: 8];
            req[i].id   = bus.req_id_i[i*ID_W +: ID_W];
            eligible[i] = bus.req_valid_i[i] && (cnt_q[i] < CntW'(MAX_OUTSTANDING))
                          && !busy_q[req[i].id];
        end
    end

    mem_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (pick_grant),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    // The slot may be refilled in the same cycle it hands its AR over.
    assign grant_valid = pick_valid && (!ar_valid_q || bus.ar_ready_i) && !rst_i;

    assign r_owner = owner_q[bus.r_id_i];
    assign r_busy  = busy_q[bus.r_id_i];

    // Beats for an ID nobody owns are sunk so a stray response cannot stall the bus.
    always_comb begin
        rsp_valid = '0;
        r_ready   = bus.r_valid_i;
        if (r_busy) begin
            rsp_valid[r_owner] = bus.r_valid_i;
            r_ready            = bus.rsp_ready_i[r_owner];
        end
        if (rst_i) begin
            rsp_valid = '0;
            r_ready   = 1'b0;
        end
    end

    assign r_done = bus.r_valid_i && r_ready && bus.r_last_i && r_busy;

    always_comb begin
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        ar_d       = ar_q;
        ar_valid_d = ar_valid_q;
        err_d      = err_q | (bus.r_valid_i & ~r_busy);
        if (ar_valid_q && bus.ar_ready_i) ar_valid_d = 1'b0;
        if (r_done) busy_d[bus.r_id_i] = 1'b0;
        if (grant_valid) begin
            ar_valid_d                 = 1'b1;
            ar_d                       = req[pick_idx];
            ptr_d                      = (pick_idx == IdxW'(NUM_REQ - 1)) ? '0
                                                                          : pick_idx + IdxW'(1);
            busy_d[req[pick_idx].id]  = 1'b1;
            owner_d[req[pick_idx].id] = pick_idx;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i] + CntW'(grant_valid && (pick_idx == IdxW'(i)))
                                - CntW'(r_done && (r_owner == IdxW'(i)));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            busy_q     <= '0;
            ar_q       <= '0;
            ar_valid_q <= 1'b0;
            err_q      <= 1'b0;
            for (int unsigned k = 0; k < NumIds; k++) owner_q[k] <= '0;
            for (int unsigned k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
        end else begin
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            ar_q       <= ar_d;
            ar_valid_q <= ar_valid_d;
            err_q      <= err_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.req_ready_o = grant_valid ? pick_grant : '0;
    assign bus.ar_valid_o  = ar_valid_q;
    assign bus.ar_addr_o   = ar_q.addr;
    assign bus.ar_len_o    = ar_q.len;
    assign bus.ar_id_o     = ar_q.id;
    assign bus.r_ready_o   = r_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_last_o  = bus.r_last_i;
    assign bus.rsp_data_o  = bus.r_data_i[DATA_W-1:0];
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Directed bench for axi_rd_scheduler: AR and R scoreboards fed from the stimulus,
// with cycle-accurate grant/issue checks.
module tb_axi_rd_scheduler;
    import axi_rd_scheduler_pkg::*;

    localparam int NR = 3;
    localparam int AW = 40;
    localparam int IW = 4;
    localparam int DW = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_rd_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) bus ();

    axi_rd_scheduler #(
        .NUM_REQ         (NR),
        .ADDR_W          (AW),
        .ID_W            (IW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [7:0]    len;
        logic [AW-1:0] addr;
    } ar_exp_t;

    typedef struct packed {
        logic [NR-1:0] vld;
        logic          last;
        logic [DW-1:0] data;
    } r_exp_t;

    ar_exp_t ar_sb[$];
    r_exp_t  r_sb[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc_n   = 0;
    int ar_cnt  = 0;
    int ar_hs_cyc, ar_hs_id, r_hs_cyc;
    int grant_cyc [NR];
    int ar_cyc [16];
    logic [NR-1:0] rdy_seen;
    logic ar_hs, r_hs;
    logic [AW-1:0] s_addr [NR];
    logic [7:0]    s_len [NR];
    logic [IW-1:0] s_id [NR];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: sample handshakes at the falling edge, then retire accepted requests.
    task automatic cyc();
        ar_exp_t ea;
        r_exp_t  er;
        @(negedge clk);
        rdy_seen = bus.req_ready_o;
        ar_hs    = bus.ar_valid_o && bus.ar_ready_i;
        r_hs     = bus.r_valid_i && bus.r_ready_o;
        for (int i = 0; i < NR; i++) if (rdy_seen[i]) grant_cyc[i] = cyc_n;
        if (ar_hs) begin
            ar_cnt++;
            ar_hs_cyc = cyc_n;
            ar_hs_id  = int'(bus.ar_id_o);
            if (ar_cyc[bus.ar_id_o] < 0) ar_cyc[bus.ar_id_o] = cyc_n;
            chk("ar_sb_has_entry", DW'(ar_sb.size() != 0), 1);
            if (ar_sb.size() != 0) begin
                ea = ar_sb.pop_front();
                chk("ar_id", bus.ar_id_o, ea.id);
                chk("ar_addr", bus.ar_addr_o, ea.addr);
                chk("ar_len", bus.ar_len_o, ea.len);
            end
        end
        if (r_hs) r_hs_cyc = cyc_n;
        if (r_hs && bus.rsp_valid_o != '0) begin
            chk("r_sb_has_entry", DW'(r_sb.size() != 0), 1);
            if (r_sb.size() != 0) begin
                er = r_sb.pop_front();
                chk("rsp_valid", bus.rsp_valid_o, er.vld);
                chk("rsp_last", bus.rsp_last_o, er.last);
                chk("rsp_data", bus.rsp_data_o, er.data);
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
        for (int i = 0; i < NR; i++) begin
            if (rdy_seen[i]) begin
                ar_sb.push_back('{id: s_id[i], len: s_len[i], addr: s_addr[i]});
                bus.req_valid_i[i] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int i, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len);
        s_id[i] = id;
        s_addr[i] = addr;
        s_len[i] = len;
        bus.req_id_i[i*IW +: IW]   = id;
        bus.req_addr_i[i*AW +: AW] = addr;
        bus.req_len_i[i*8 +: 8]    = len;
        bus.req_valid_i[i]         = 1'b1;
    endtask

    task automatic wait_grant(input int i, input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            got = rdy_seen[i];
        end
        chk(tag, DW'(got), 1);
    endtask

    task automatic r_beat(input logic [IW-1:0] id, input logic last, input logic [DW-1:0] data,
                          input logic [NR-1:0] owner, input string tag);
        logic got;
        bus.r_valid_i = 1'b1;
        bus.r_id_i    = id;
        bus.r_last_i  = last;
        bus.r_data_i  = data;
        r_sb.push_back('{vld: owner, last: last, data: data});
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cyc();
            got = r_hs;
        end
        chk(tag, DW'(got), 1);
        bus.r_valid_i = 1'b0;
        bus.r_last_i  = 1'b0;
    endtask

    task automatic do_reset();
        chk("sb_drained", DW'(ar_sb.size() + r_sb.size()), 0);
        rst = 1'b1;
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.req_len_i   = '0;
        bus.req_id_i    = '0;
        bus.ar_ready_i  = 1'b0;
        bus.r_valid_i   = 1'b0;
        bus.r_id_i      = '0;
        bus.r_last_i    = 1'b0;
        bus.r_data_i    = '0;
        bus.rsp_ready_i = '0;
        ar_sb.delete();
        r_sb.delete();
        ar_cnt = 0;
        for (int i = 0; i < NR; i++) grant_cyc[i] = -1;
        for (int i = 0; i < 16; i++) ar_cyc[i] = -1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset, idle outputs, unowned R beat.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_outputs", {bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_id_o,
                bus.req_ready_o, bus.rsp_valid_o, bus.r_ready_o, bus.err_o}, '0);
        end
        @(posedge clk);
        #1;
        bus.r_valid_i = 1'b1;
        bus.r_id_i    = 4'd3;
        bus.r_last_i  = 1'b1;
        @(negedge clk);
        chk("unowned_r_ready", bus.r_ready_o, 1);
        chk("unowned_rsp_valid", bus.rsp_valid_o, 0);
        chk("err_before_edge", bus.err_o, 0);
        @(posedge clk);
        #1;
        bus.r_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("err_sticky", bus.err_o, 1);

        // Three requesters, round-robin issue, 4-beat burst to id 2.
        do_reset();
        bus.ar_ready_i  = 1'b1;
        bus.rsp_ready_i = '1;
        set_req(0, 4'd1, 40'h100, 8'd0);
        set_req(1, 4'd2, 40'h200, 8'd3);
        set_req(2, 4'd3, 40'h300, 8'd1);
        repeat (6) cyc();
        chk("rr_grant1", grant_cyc[1], grant_cyc[0] + 1);
        chk("rr_grant2", grant_cyc[2], grant_cyc[0] + 2);
        chk("ar_latency", ar_cyc[1], grant_cyc[0] + 1);
        chk("ar_b2b_2", ar_cyc[2], ar_cyc[1] + 1);
        chk("ar_b2b_3", ar_cyc[3], ar_cyc[2] + 1);
        chk("ar_count3", ar_cnt, 3);
        for (int b = 0; b < 4; b++)
            r_beat(4'd2, (b == 3), {16{32'hA5A5_0000 + b}}, 3'b010, "burst_beat_hs");

        // Same ID from two requesters.
        do_reset();
        bus.ar_ready_i  = 1'b1;
        bus.rsp_ready_i = '1;
        set_req(0, 4'd5, 40'h500, 8'd0);
        set_req(1, 4'd5, 40'h510, 8'd0);
        wait_grant(0, "sameid_first");
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("sameid_blocked", rdy_seen[1], 0);
        end
        r_beat(4'd5, 1'b1, {16{32'h5555_0005}}, 3'b001, "sameid_r_hs");
        wait_grant(1, "sameid_regrant");
        chk("sameid_grant_cycle", grant_cyc[1], r_hs_cyc + 1);
        cyc();
        chk("sameid_ar_delay", ar_hs_cyc - r_hs_cyc, 2);
        chk("sameid_ar_id", ar_hs_id, 5);

        // Outstanding cap on requester 0.
        do_reset();
        bus.ar_ready_i  = 1'b1;
        bus.rsp_ready_i = '1;
        for (int k = 0; k < 4; k++) begin
            set_req(0, IW'(k), 40'h1000 + AW'(k * 'h40), 8'd7);
            wait_grant(0, "cap_accept");
        end
        set_req(0, 4'd4, 40'h1100, 8'd7);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("cap_masked", rdy_seen[0], 0);
        end
        chk("cap_ar_count", ar_cnt, 4);
        r_beat(4'd0, 1'b1, {16{32'hCAFE_0000}}, 3'b001, "cap_r_hs");
        wait_grant(0, "cap_release");
        repeat (2) cyc();
        chk("cap_ar_count_after", ar_cnt, 5);

        // AR back-pressure holds the slot stable; drain cycle re-grants.
        do_reset();
        bus.rsp_ready_i = '1;
        set_req(2, 4'd7, 40'h70_0000_1234, 8'h0f);
        wait_grant(2, "stall_first");
        set_req(0, 4'd8, 40'h800, 8'd1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("stall_no_ready", rdy_seen, 0);
            chk("stall_ar_stable", {bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_id_o},
                {1'b1, 40'h70_0000_1234, 8'h0f, 4'h7});
        end
        bus.ar_ready_i = 1'b1;
        cyc();
        chk("drain_grant", rdy_seen, 3'b001);
        repeat (2) cyc();
        chk("stall_ar_count", ar_cnt, 2);

        // Response back-pressure, then reset mid-burst.
        do_reset();
        bus.ar_ready_i  = 1'b1;
        bus.rsp_ready_i = '1;
        set_req(1, 4'd9, 40'h900, 8'd3);
        wait_grant(1, "bp_grant");
        repeat (2) cyc();
        bus.rsp_ready_i = 3'b101;
        bus.r_valid_i   = 1'b1;
        bus.r_id_i      = 4'd9;
        bus.r_last_i    = 1'b0;
        bus.r_data_i    = {16{32'h0BAD_BEEF}};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_r_ready", bus.r_ready_o, 0);
            chk("bp_rsp_valid", bus.rsp_valid_o, 3'b010);
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("rst_outputs", {bus.ar_valid_o, bus.req_ready_o, bus.rsp_valid_o, bus.r_ready_o,
            bus.err_o}, '0);
        bus.r_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.r_valid_i = 1'b1;
        bus.r_last_i  = 1'b1;
        @(negedge clk);
        chk("cleared_rsp_valid", bus.rsp_valid_o, 0);
        chk("cleared_r_ready", bus.r_ready_o, 1);
        @(posedge clk);
        #1;
        bus.r_valid_i = 1'b0;
        @(negedge clk);
        chk("cleared_err", bus.err_o, 1);
        chk("final_ar_sb", ar_sb.size(), 0);
        chk("final_r_sb", r_sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
